// File: rtl/unified_mem_arb.sv
// unified_mem_arb
// Unified instruction/data memory shared by the IF and MEM stages of the
// RV32I pipeline. One byte-addressed array, two request ports, one access
// in flight at a time.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   if_req / if_addr        fetch request; held until if_valid
//   if_rdata                FETCH_WORDS little-endian words from if_addr+4k
//   if_valid / if_fault     one-cycle response pulse, misaligned-fetch flag
//   d_req / d_addr          data request; held with the other d_* inputs
//   d_MemRead / d_MemWrite  size code: 01 byte, 10 half, 11 word, 00 none
//   d_wdata / d_unsigned    store data, zero-extend loads when set
//   d_rdata                 extended load data
//   d_valid / d_fault       one-cycle response pulse, data fault flag
module unified_mem_arb #(
   parameter int SIZE        = 4096,
   parameter int ADDR_WIDTH  = 12,
   parameter int INSTR_END   = 2048,
   parameter int FETCH_WORDS = 3,
   parameter int WAIT_CYCLES = 0,
   parameter     INIT_FILE   = ""
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     if_req,
   input  logic [ADDR_WIDTH-1:0]    if_addr,
   output logic [32*FETCH_WORDS-1:0] if_rdata,
   output logic                     if_valid,
   output logic                     if_fault,
   input  logic                     d_req,
   input  logic [ADDR_WIDTH-1:0]    d_addr,
   input  logic [1:0]               d_MemRead,
   input  logic [1:0]               d_MemWrite,
   input  logic [31:0]              d_wdata,
   input  logic                     d_unsigned,
   output logic [31:0]              d_rdata,
   output logic                     d_valid,
   output logic                     d_fault
);
   localparam int DATA_SIZE = SIZE - INSTR_END;
   localparam int IDX_W     = $clog2(SIZE);
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [7:0] mem [SIZE];

   state_t                state_reg;
   logic [3:0]            cnt_reg;
   logic                  last_grant_reg;   // 0 = fetch, 1 = data
   logic                  gnt_data_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [1:0]            rd_reg;
   logic [1:0]            wr_reg;
   logic [31:0]           wdata_reg;
   logic                  uns_reg;

   // Data addresses above the instruction region wrap inside the data region.
   function automatic logic [IDX_W-1:0] dmap(input logic [31:0] a);
      logic [31:0] m;
      if (a < 32'(INSTR_END)) m = a;
      else m = 32'(INSTR_END) + (a - 32'(INSTR_END)) % 32'(DATA_SIZE);
      return m[IDX_W-1:0];
   endfunction

   // Fetches wrap inside the instruction region.
   function automatic logic [IDX_W-1:0] fmap(input logic [31:0] a);
      logic [31:0] m;
      m = a % 32'(INSTR_END);
      return m[IDX_W-1:0];
   endfunction

   logic                  any_req, tie_data, cur_data, do_access;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [1:0]            cur_rd, cur_wr;
   logic [31:0]           cur_wdata, cur_a32, load_word, load_ext;
   logic                  cur_uns, dfault, ffault;
   logic [32*FETCH_WORDS-1:0] fetch_word;

   assign any_req  = if_req | d_req;
   // Data wins unless fetch also asks and data was the last port served.
   assign tie_data = d_req & (~if_req | ~last_grant_reg);

   // With no wait states the access happens on the grant edge itself, so the
   // live inputs are used in IDLE; otherwise the latched copies are used.
   always_comb begin
      if (state_reg == IDLE) begin
         cur_data  = tie_data;
         cur_addr  = tie_data ? d_addr : if_addr;
         cur_rd    = d_MemRead;
         cur_wr    = d_MemWrite;
         cur_wdata = d_wdata;
         cur_uns   = d_unsigned;
      end else begin
         cur_data  = gnt_data_reg;
         cur_addr  = addr_reg;
         cur_rd    = rd_reg;
         cur_wr    = wr_reg;
         cur_wdata = wdata_reg;
         cur_uns   = uns_reg;
      end
   end

   assign cur_a32   = 32'(cur_addr);
   assign do_access = ((state_reg == IDLE) && any_req && (WAIT_CYCLES == 0)) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd1));

   assign dfault = ((cur_rd != 2'b00) && (cur_wr != 2'b00)) ||
                   (((cur_rd == 2'b10) || (cur_wr == 2'b10)) && cur_addr[0]) ||
                   (((cur_rd == 2'b11) || (cur_wr == 2'b11)) && (cur_addr[1:0] != 2'b00)) ||
                   ((cur_wr != 2'b00) && (cur_a32 < 32'(INSTR_END)));
   assign ffault = (cur_addr[1:0] != 2'b00);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_load
         assign load_word[8*gi +: 8] = mem[dmap(cur_a32 + 32'(gi))];
      end
      for (gi = 0; gi < 4*FETCH_WORDS; gi++) begin : g_fetch
         assign fetch_word[8*gi +: 8] = mem[fmap(cur_a32 + 32'(gi))];
      end
   endgenerate

   always_comb begin
      load_ext = 32'd0;
      case (cur_rd)
         2'b01:   load_ext = cur_uns ? {24'd0, load_word[7:0]}
                                     : {{24{load_word[7]}}, load_word[7:0]};
         2'b10:   load_ext = cur_uns ? {16'd0, load_word[15:0]}
                                     : {{16{load_word[15]}}, load_word[15:0]};
         2'b11:   load_ext = load_word;
         default: load_ext = 32'd0;
      endcase
   end

   // The array sits in the reset-guarded branch so that a reset arriving
   // before the access edge also cancels the write; its contents are never
   // cleared.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         last_grant_reg <= 1'b0;
         gnt_data_reg   <= 1'b0;
         addr_reg       <= '0;
         rd_reg         <= 2'b00;
         wr_reg         <= 2'b00;
         wdata_reg      <= 32'd0;
         uns_reg        <= 1'b0;
         if_rdata       <= '0;
         if_valid       <= 1'b0;
         if_fault       <= 1'b0;
         d_rdata        <= 32'd0;
         d_valid        <= 1'b0;
         d_fault        <= 1'b0;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if (do_access) begin
            if (cur_data) begin
               d_valid <= 1'b1;
               d_fault <= dfault;
               d_rdata <= dfault ? 32'd0 : load_ext;
               if (!dfault && (cur_wr != 2'b00)) begin
                  mem[dmap(cur_a32)] <= cur_wdata[7:0];
                  if (cur_wr[1])
                     mem[dmap(cur_a32 + 32'd1)] <= cur_wdata[15:8];
                  if (cur_wr == 2'b11) begin
                     mem[dmap(cur_a32 + 32'd2)] <= cur_wdata[23:16];
                     mem[dmap(cur_a32 + 32'd3)] <= cur_wdata[31:24];
                  end
               end
            end else begin
               if_valid <= 1'b1;
               if_fault <= ffault;
               if_rdata <= ffault ? '0 : fetch_word;
            end
         end
         case (state_reg)
            IDLE: if (any_req) begin
               last_grant_reg <= tie_data;
               gnt_data_reg   <= tie_data;
               addr_reg       <= cur_addr;
               rd_reg         <= d_MemRead;
               wr_reg         <= d_MemWrite;
               wdata_reg      <= d_wdata;
               uns_reg        <= d_unsigned;
               cnt_reg        <= WAIT_LD;
               state_reg      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               if (cnt_reg == 4'd1) state_reg <= RESP;
            end
            RESP:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_unified_mem_arb.sv
module tb_unified_mem_arb;
   localparam int AW = 13, FW = 3, WC = 2;

   logic clk = 1'b0;
   logic reset;
   logic if_req;
   logic [AW-1:0] if_addr;
   logic [32*FW-1:0] if_rdata;
   logic if_valid, if_fault;
   logic d_req;
   logic [AW-1:0] d_addr;
   logic [1:0] d_MemRead, d_MemWrite;
   logic [31:0] d_wdata;
   logic d_unsigned;
   logic [31:0] d_rdata;
   logic d_valid, d_fault;

   int checks = 0;
   int fails  = 0;

   typedef struct { logic [31:0] rdata; logic fault; string name; } d_exp_t;
   typedef struct { logic [32*FW-1:0] rdata; logic fault; string name; } f_exp_t;
   d_exp_t dq[$];
   f_exp_t fq[$];
   d_exp_t de;
   f_exp_t fe;

   localparam logic [32*FW-1:0] FETCH0 = {32'h002081b3, 32'h01400113, 32'h00a00093};

   unified_mem_arb #(.SIZE(4096), .ADDR_WIDTH(AW), .INSTR_END(2048),
                     .FETCH_WORDS(FW), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_fault(if_fault),
      .d_req(d_req), .d_addr(d_addr), .d_MemRead(d_MemRead), .d_MemWrite(d_MemWrite),
      .d_wdata(d_wdata), .d_unsigned(d_unsigned), .d_rdata(d_rdata),
      .d_valid(d_valid), .d_fault(d_fault)
   );

   always #5 clk = ~clk;

   // Scoreboard: every response pulse pops the oldest expectation of its port.
   always @(negedge clk) begin
      if (!reset) begin
         if (d_valid && if_valid) begin
            checks++; fails++;
            $display("FAIL overlap: both valid pulses high together");
         end
         if (d_valid) begin
            checks++;
            if (dq.size() == 0) begin
               fails++;
               $display("FAIL d_unexpected: rdata=%h fault=%b with no request pending", d_rdata, d_fault);
            end else begin
               de = dq.pop_front();
               if (d_rdata !== de.rdata || d_fault !== de.fault) begin
                  fails++;
                  $display("FAIL %s: got rdata=%h fault=%b, expected rdata=%h fault=%b",
                           de.name, d_rdata, d_fault, de.rdata, de.fault);
               end else
                  $display("data  %-14s rdata=%h fault=%b", de.name, d_rdata, d_fault);
            end
         end
         if (if_valid) begin
            checks++;
            if (fq.size() == 0) begin
               fails++;
               $display("FAIL if_unexpected: rdata=%h fault=%b with no request pending", if_rdata, if_fault);
            end else begin
               fe = fq.pop_front();
               if (if_rdata !== fe.rdata || if_fault !== fe.fault) begin
                  fails++;
                  $display("FAIL %s: got rdata=%h fault=%b, expected rdata=%h fault=%b",
                           fe.name, if_rdata, if_fault, fe.rdata, fe.fault);
               end else
                  $display("fetch %-14s rdata=%h fault=%b", fe.name, if_rdata, if_fault);
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic preload(input int a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) dut.mem[a + k] = w[8*k +: 8];
   endtask

   // One data transaction; also checks grant-to-valid latency from an idle start.
   task automatic do_data(input logic [AW-1:0] a, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [31:0] wd, input logic uns,
                          input logic [31:0] exp_rd, input logic exp_f, input string name);
      d_exp_t e;
      int n;
      bit seen;
      n = 0; seen = 0;
      e.rdata = exp_rd; e.fault = exp_f; e.name = name;
      dq.push_back(e);
      d_addr = a; d_MemRead = rd; d_MemWrite = wr; d_wdata = wd; d_unsigned = uns;
      d_req = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (d_valid) seen = 1;
      end
      d_req = 1'b0;
      checks++;
      if (!seen || n != WC + 1) begin
         fails++;
         $display("FAIL %s_latency: got %0d edges (seen=%0d), expected %0d", name, n, seen, WC + 1);
      end
      @(negedge clk);
   endtask

   task automatic do_fetch(input logic [AW-1:0] a, input logic [32*FW-1:0] exp_rd,
                           input logic exp_f, input string name);
      f_exp_t e;
      int n;
      bit seen;
      n = 0; seen = 0;
      e.rdata = exp_rd; e.fault = exp_f; e.name = name;
      fq.push_back(e);
      if_addr = a; if_req = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (if_valid) seen = 1;
      end
      if_req = 1'b0;
      checks++;
      if (!seen || n != WC + 1) begin
         fails++;
         $display("FAIL %s_latency: got %0d edges (seen=%0d), expected %0d", name, n, seen, WC + 1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      if_req = 0; if_addr = '0; d_req = 0; d_addr = '0;
      d_MemRead = 0; d_MemWrite = 0; d_wdata = 0; d_unsigned = 0;
      preload(0, 32'h00a00093);
      preload(4, 32'h01400113);
      preload(8, 32'h002081b3);
      preload(2044, 32'haabbccdd);
      repeat (3) @(negedge clk);
      checks++;
      if ({if_rdata, if_valid, if_fault, d_rdata, d_valid, d_fault} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: if_rdata=%h if_valid=%b if_fault=%b d_rdata=%h d_valid=%b d_fault=%b, expected all 0",
                  if_rdata, if_valid, if_fault, d_rdata, d_valid, d_fault);
      end else $display("reset outputs all zero");
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_fetch();
      do_fetch(13'h000, FETCH0, 1'b0, "fetch_0x000");
   endtask

   task automatic test_store_load();
      do_data(13'h800, 2'b00, 2'b11, 32'hdeadbeef, 0, 32'h0, 0, "sw_800");
      do_data(13'h800, 2'b11, 2'b00, 32'h0, 0, 32'hdeadbeef, 0, "lw_800");
      do_data(13'h803, 2'b01, 2'b00, 32'h0, 0, 32'hffffffde, 0, "lb_803");
      do_data(13'h803, 2'b01, 2'b00, 32'h0, 1, 32'h000000de, 0, "lbu_803");
      do_data(13'h802, 2'b10, 2'b00, 32'h0, 0, 32'hffffdead, 0, "lh_802");
      do_data(13'h800, 2'b10, 2'b00, 32'h0, 1, 32'h0000beef, 0, "lhu_800");
      do_data(13'h804, 2'b00, 2'b11, 32'h55667788, 0, 32'h0, 0, "sw_804");
      do_data(13'h804, 2'b00, 2'b10, 32'hffff1234, 0, 32'h0, 0, "sh_804");
      do_data(13'h807, 2'b00, 2'b01, 32'hffffff9a, 0, 32'h0, 0, "sb_807");
      do_data(13'h804, 2'b11, 2'b00, 32'h0, 0, 32'h9a661234, 0, "lw_804");
      repeat (2) @(negedge clk);
      checks++;
      if (d_rdata !== 32'h9a661234 || d_valid !== 1'b0 || if_rdata !== FETCH0) begin
         fails++;
         $display("FAIL hold: d_rdata=%h d_valid=%b if_rdata=%h, expected %h 0 %h",
                  d_rdata, d_valid, if_rdata, 32'h9a661234, FETCH0);
      end else $display("hold d_rdata and if_rdata after response");
      do_data(13'h804, 2'b00, 2'b00, 32'h0, 0, 32'h0, 0, "none_804");
   endtask

   task automatic test_faults();
      do_data(13'h000, 2'b00, 2'b11, 32'h0, 0, 32'h0, 1, "sw_instr");
      do_data(13'h000, 2'b11, 2'b00, 32'h0, 0, 32'h00a00093, 0, "lw_000_after");
      do_data(13'h801, 2'b11, 2'b00, 32'h0, 0, 32'h0, 1, "lw_801_mis");
      do_data(13'h805, 2'b00, 2'b10, 32'hffffffff, 0, 32'h0, 1, "sh_805_mis");
      do_data(13'h804, 2'b11, 11'b00, 32'h0, 0, 32'h9a661234, 0, "lw_804_after");
      do_data(13'h804, 2'b11, 2'b11, 32'h0, 0, 32'h0, 1, "rd_wr_both");
      do_data(13'h804, 2'b11, 2'b00, 32'h0, 0, 32'h9a661234, 0, "lw_804_again");
      do_fetch(13'h002, '0, 1'b1, "fetch_0x002");
   endtask

   task automatic test_arbitration();
      int t[4];
      bit isd[4];
      int cnt, cyc;
      d_exp_t e;
      f_exp_t f;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         e.rdata = 32'hdeadbeef; e.fault = 0; e.name = "arb_lw_800"; dq.push_back(e);
         f.rdata = FETCH0; f.fault = 0; f.name = "arb_fetch_000"; fq.push_back(f);
      end
      d_addr = 13'h800; d_MemRead = 2'b11; d_MemWrite = 2'b00; d_unsigned = 0;
      if_addr = 13'h000;
      d_req = 1'b1; if_req = 1'b1;
      cnt = 0; cyc = 0;
      for (int i = 0; i < 40 && cnt < 4; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (d_valid || if_valid) begin
            t[cnt] = cyc; isd[cnt] = d_valid; cnt++;
         end
      end
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      checks++;
      if (cnt != 4 || isd[0] !== 1'b1 || isd[1] !== 1'b0 || isd[2] !== 1'b1 || isd[3] !== 1'b0) begin
         fails++;
         $display("FAIL arb_order: got %0d grants order d=%b%b%b%b, expected 4 grants d=1010",
                  cnt, isd[0], isd[1], isd[2], isd[3]);
      end else $display("arbitration order data,fetch,data,fetch");
      checks++;
      if (t[0] != WC + 1 || t[1] - t[0] != WC + 2 || t[2] - t[1] != WC + 2 || t[3] - t[2] != WC + 2) begin
         fails++;
         $display("FAIL arb_spacing: valid edges %0d %0d %0d %0d, expected %0d then spacing %0d",
                  t[0], t[1], t[2], t[3], WC + 1, WC + 2);
      end else $display("arbitration spacing %0d cycles", WC + 2);
   endtask

   task automatic test_wrap();
      do_fetch(13'h7fc, {32'h01400113, 32'h00a00093, 32'haabbccdd}, 1'b0, "fetch_wrap");
      do_data(13'h1000, 2'b00, 2'b11, 32'h12345678, 0, 32'h0, 0, "sw_1000");
      do_data(13'h0800, 2'b11, 2'b00, 32'h0, 0, 32'h12345678, 0, "lw_800_alias");
   endtask

   task automatic test_reset_mid();
      bit spurious;
      do_data(13'h900, 2'b00, 2'b11, 32'h11223344, 0, 32'h0, 0, "sw_900_pre");
      d_addr = 13'h900; d_MemRead = 2'b00; d_MemWrite = 2'b11; d_wdata = 32'hcafef00d;
      d_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1; d_req = 1'b0;
      #1;
      checks++;
      if ({if_rdata, if_valid, if_fault, d_rdata, d_valid, d_fault} !== '0) begin
         fails++;
         $display("FAIL reset_mid_outputs: if_rdata=%h d_rdata=%h d_valid=%b d_fault=%b, expected all 0",
                  if_rdata, d_rdata, d_valid, d_fault);
      end else $display("reset mid-operation outputs all zero");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (d_valid) spurious = 1;
      end
      checks++;
      if (spurious) begin
         fails++;
         $display("FAIL reset_mid_valid: got d_valid after cancelled access, expected none");
      end else $display("cancelled access produced no d_valid");
      do_data(13'h900, 2'b11, 2'b00, 32'h0, 0, 32'h11223344, 0, "lw_900_after");
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_load();
      test_faults();
      test_arbitration();
      test_wrap();
      test_reset_mid();
      repeat (3) @(negedge clk);
      checks++;
      if (dq.size() != 0 || fq.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d data and %0d fetch responses missing, expected 0 and 0",
                  dq.size(), fq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
